// File: rtl/vga_pkg.sv
// Shared constants for the 640x480 @ 60 Hz raster: segment lengths, derived
// totals and sync windows, counter and index widths.
package vga_pkg;

    localparam int unsigned H_ACTIVE_640 = 640;
    localparam int unsigned H_FP_640     = 16;
    localparam int unsigned H_SYNC_640   = 96;
    localparam int unsigned H_BP_640     = 48;
    localparam int unsigned H_TOTAL_640  = H_ACTIVE_640 + H_FP_640 + H_SYNC_640 + H_BP_640;
    localparam int unsigned HSYNC_START_640 = H_ACTIVE_640 + H_FP_640;
    localparam int unsigned HSYNC_END_640   = HSYNC_START_640 + H_SYNC_640 - 1;

    localparam int unsigned V_ACTIVE_640 = 480;
    localparam int unsigned V_FP_640     = 10;
    localparam int unsigned V_SYNC_640   = 2;
    localparam int unsigned V_BP_640     = 33;
    localparam int unsigned V_TOTAL_640  = V_ACTIVE_640 + V_FP_640 + V_SYNC_640 + V_BP_640;
    localparam int unsigned VSYNC_START_640 = V_ACTIVE_640 + V_FP_640;
    localparam int unsigned VSYNC_END_640   = VSYNC_START_640 + V_SYNC_640 - 1;

    localparam int unsigned HCNT_W = 10;
    localparam int unsigned VCNT_W = 10;
    localparam int unsigned HIDX_W = 10;
    localparam int unsigned VIDX_W = 9;

    // Width of a counter spanning 0..n-1; a modulo-1 counter still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counterN_en.sv
// Modulo-N up-counter with synchronous clear, count enable and a wrap flag
// that is high in the cycle the counter steps from N-1 back to 0.
module counterN_en #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic [W-1:0] o_cnt_nxt_c,
    output logic         o_wrap_c
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         wrap_c;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_c = 1'b0;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                wrap_c = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt       = cnt_q;
    assign o_cnt_nxt_c = cnt_d;
    assign o_wrap_c    = wrap_c;

endmodule

// File: rtl/vga_timing_640_480.sv
// Raster timing controller: pixel-rate enable, h/v counters, registered
// active-area indices, syncs, line strobe and divided frame strobe.
module vga_timing_640_480
    import vga_pkg::*;
#(
    parameter int unsigned PX_DIV    = 4,
    parameter int unsigned H_ACTIVE  = H_ACTIVE_640,
    parameter int unsigned H_FP      = H_FP_640,
    parameter int unsigned H_SYNC    = H_SYNC_640,
    parameter int unsigned H_BP      = H_BP_640,
    parameter int unsigned V_ACTIVE  = V_ACTIVE_640,
    parameter int unsigned V_FP      = V_FP_640,
    parameter int unsigned V_SYNC    = V_SYNC_640,
    parameter int unsigned V_BP      = V_BP_640,
    parameter int unsigned FRAME_DIV = 1
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    output logic              o_px_clk,
    output logic [HIDX_W-1:0] o_hidx,
    output logic [VIDX_W-1:0] o_vidx,
    output logic              o_haddr_enb,
    output logic              o_vaddr_enb,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_line_en,
    output logic              o_frame_en
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = cnt_width(PX_DIV);
    localparam int unsigned F_W     = cnt_width(FRAME_DIV);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(PX_DIV - 1);
    localparam logic [HCNT_W-1:0] H_ACT_C    = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] H_LAST     = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] HS_START   = HCNT_W'(H_ACTIVE + H_FP);
    localparam logic [HCNT_W-1:0] HS_END     = HCNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VCNT_W-1:0] V_ACT_C    = VCNT_W'(V_ACTIVE);
    localparam logic [VCNT_W-1:0] V_ACT_LAST = VCNT_W'(V_ACTIVE - 1);
    localparam logic [VCNT_W-1:0] VS_START   = VCNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCNT_W-1:0] VS_END     = VCNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [F_W-1:0]    F_LAST     = F_W'(FRAME_DIV - 1);

    logic              clr_c;
    logic              tick_c;
    logic              frame_tick_c;

    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_nxt;
    logic              div_wrap_c;
    logic [HCNT_W-1:0] h_cnt;
    logic [HCNT_W-1:0] h_nxt;
    logic              h_wrap_c;
    logic [VCNT_W-1:0] v_cnt;
    logic [VCNT_W-1:0] v_nxt;
    logic              v_wrap_c;

    logic [F_W-1:0]    f_q,     f_d;
    logic              px_q,    px_d;
    logic [HIDX_W-1:0] hidx_q,  hidx_d;
    logic [VIDX_W-1:0] vidx_q,  vidx_d;
    logic              haddr_q, haddr_d;
    logic              vaddr_q, vaddr_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              line_q,  line_d;
    logic              frame_q, frame_d;

    // A tick is the cycle in which o_px_clk is already high and the divider wraps.
    assign clr_c        = !i_en;
    assign tick_c       = px_q && div_wrap_c;
    assign frame_tick_c = h_wrap_c && (v_cnt == V_ACT_LAST);

    counterN_en #(.N(PX_DIV), .W(DIV_W)) u_div_cnt (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_clr       (clr_c),
        .i_en        (i_en),
        .o_cnt       (div_cnt),
        .o_cnt_nxt_c (div_nxt),
        .o_wrap_c    (div_wrap_c)
    );

    counterN_en #(.N(H_TOTAL), .W(HCNT_W)) u_h_cnt (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_clr       (clr_c),
        .i_en        (tick_c),
        .o_cnt       (h_cnt),
        .o_cnt_nxt_c (h_nxt),
        .o_wrap_c    (h_wrap_c)
    );

    counterN_en #(.N(V_TOTAL), .W(VCNT_W)) u_v_cnt (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_clr       (clr_c),
        .i_en        (h_wrap_c),
        .o_cnt       (v_cnt),
        .o_cnt_nxt_c (v_nxt),
        .o_wrap_c    (v_wrap_c)
    );

    logic unused_c;
    assign unused_c = ^{div_cnt, h_cnt, v_wrap_c};

    // Outputs decode the next-state position so they move with the counters.
    always_comb begin
        f_d = f_q;
        if (!i_en) begin
            f_d = '0;
        end else if (frame_tick_c) begin
            f_d = (f_q == F_LAST) ? '0 : f_q + F_W'(1);
        end

        px_d    = i_en && (div_nxt == DIV_LAST);
        haddr_d = i_en && (h_nxt < H_ACT_C);
        vaddr_d = i_en && (v_nxt < V_ACT_C);
        hidx_d  = haddr_d ? HIDX_W'(h_nxt) : '0;
        vidx_d  = vaddr_d ? VIDX_W'(v_nxt) : '0;
        hsync_d = !(i_en && (h_nxt >= HS_START) && (h_nxt <= HS_END));
        vsync_d = !(i_en && (v_nxt >= VS_START) && (v_nxt <= VS_END));
        line_d  = px_d && (h_nxt == H_LAST);
        frame_d = line_d && (v_nxt == V_ACT_LAST) && (f_d == F_LAST);
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            f_q     <= '0;
            px_q    <= 1'b0;
            hidx_q  <= '0;
            vidx_q  <= '0;
            haddr_q <= 1'b0;
            vaddr_q <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            f_q     <= f_d;
            px_q    <= px_d;
            hidx_q  <= hidx_d;
            vidx_q  <= vidx_d;
            haddr_q <= haddr_d;
            vaddr_q <= vaddr_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            line_q  <= line_d;
            frame_q <= frame_d;
        end
    end

    assign o_px_clk    = px_q;
    assign o_hidx      = hidx_q;
    assign o_vidx      = vidx_q;
    assign o_haddr_enb = haddr_q;
    assign o_vaddr_enb = vaddr_q;
    assign o_hsync     = hsync_q;
    assign o_vsync     = vsync_q;
    assign o_line_en   = line_q;
    assign o_frame_en  = frame_q;

endmodule

// File: tb/tb_vga_timing_640_480.sv
// Bench for vga_timing_640_480: three geometries checked every cycle against
// an arithmetic raster model driven by the count of enabled cycles.
module tb_vga_timing_640_480;

    localparam int NDUT = 3;
    localparam int PXD [NDUT] = '{4, 1, 3};
    localparam int HA  [NDUT] = '{640, 16, 8};
    localparam int HFP [NDUT] = '{16, 2, 1};
    localparam int HS  [NDUT] = '{96, 3, 2};
    localparam int HBP [NDUT] = '{48, 3, 1};
    localparam int VA  [NDUT] = '{480, 6, 4};
    localparam int VFP [NDUT] = '{10, 1, 1};
    localparam int VS  [NDUT] = '{2, 2, 1};
    localparam int VBP [NDUT] = '{33, 1, 1};
    localparam int FD  [NDUT] = '{1, 3, 1};

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       px    [NDUT];
    logic [9:0] hidx  [NDUT];
    logic [8:0] vidx  [NDUT];
    logic       ha_o  [NDUT];
    logic       va_o  [NDUT];
    logic       hs_o  [NDUT];
    logic       vs_o  [NDUT];
    logic       le    [NDUT];
    logic       fe    [NDUT];

    int total = 0;
    int bad   = 0;
    int k     = 0;
    bit go    = 1'b0;

    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            vga_timing_640_480 #(
                .PX_DIV(PXD[g]), .H_ACTIVE(HA[g]), .H_FP(HFP[g]), .H_SYNC(HS[g]),
                .H_BP(HBP[g]), .V_ACTIVE(VA[g]), .V_FP(VFP[g]), .V_SYNC(VS[g]),
                .V_BP(VBP[g]), .FRAME_DIV(FD[g])
            ) u_dut (
                .clk         (clk),
                .i_rst_n     (rst_n),
                .i_en        (en),
                .o_px_clk    (px[g]),
                .o_hidx      (hidx[g]),
                .o_vidx      (vidx[g]),
                .o_haddr_enb (ha_o[g]),
                .o_vaddr_enb (va_o[g]),
                .o_hsync     (hs_o[g]),
                .o_vsync     (vs_o[g]),
                .o_line_en   (le[g]),
                .o_frame_en  (fe[g])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    // Number of consecutive enabled clock edges since the last reset or disable.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)   k <= 0;
        else if (!en) k <= 0;
        else          k <= k + 1;
    end

    typedef struct {
        int px; int hidx; int vidx; int ha; int va; int hs; int vs; int le; int fe;
    } exp_t;

    function automatic exp_t model(input int g, input int kk);
        exp_t e;
        int ht, vt, t, h, v, f0;
        e = '{default: 0};
        e.hs = 1;
        e.vs = 1;
        if (kk == 0) return e;
        ht = HA[g] + HFP[g] + HS[g] + HBP[g];
        vt = VA[g] + VFP[g] + VS[g] + VBP[g];
        e.px = ((kk % PXD[g]) == PXD[g] - 1) ? 1 : 0;
        // Ticks already taken = earlier cycles that showed o_px_clk high.
        t = (PXD[g] == 1) ? kk - 1 : kk / PXD[g];
        h = t % ht;
        v = (t / ht) % vt;
        e.ha   = (h < HA[g]) ? 1 : 0;
        e.va   = (v < VA[g]) ? 1 : 0;
        e.hidx = e.ha ? h : 0;
        e.vidx = e.va ? v : 0;
        e.hs   = (h >= HA[g] + HFP[g] && h < HA[g] + HFP[g] + HS[g]) ? 0 : 1;
        e.vs   = (v >= VA[g] + VFP[g] && v < VA[g] + VFP[g] + VS[g]) ? 0 : 1;
        e.le   = (e.px == 1 && h == ht - 1) ? 1 : 0;
        f0 = (VA[g] - 1) * ht + ht - 1;
        if (e.le == 1 && v == VA[g] - 1 && (((t - f0) / (ht * vt)) % FD[g]) == FD[g] - 1)
            e.fe = 1;
        return e;
    endfunction

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s dut%0d k=%0d got=%0d want=%0d", nm, g, k, act, exp_v);
        end
    endtask

    always @(negedge clk) begin : cmp
        exp_t e;
        if (go) begin
            for (int g = 0; g < NDUT; g++) begin
                e = model(g, k);
                chk("px_clk",     g, 32'(px[g]),   e.px);
                chk("hidx",       g, 32'(hidx[g]), e.hidx);
                chk("vidx",       g, 32'(vidx[g]), e.vidx);
                chk("haddr_enb",  g, 32'(ha_o[g]), e.ha);
                chk("vaddr_enb",  g, 32'(va_o[g]), e.va);
                chk("hsync",      g, 32'(hs_o[g]), e.hs);
                chk("vsync",      g, 32'(vs_o[g]), e.vs);
                chk("line_en",    g, 32'(le[g]),   e.le);
                chk("frame_en",   g, 32'(fe[g]),   e.fe);
            end
        end
    end

    initial begin
        int idle_px, first_px, px0, le0, hsl0, hact0, maxh0, fe1, fe2, fe_after, hold;
        bit found;
        idle_px = 0; first_px = 0; px0 = 0; le0 = 0; hsl0 = 0; hact0 = 0;
        maxh0 = 0; fe1 = 0; fe2 = 0; fe_after = 0; hold = 0;

        #1 go = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle with enable low: no pixel pulses at all.
        repeat (6) begin
            @(negedge clk);
            for (int g = 0; g < NDUT; g++) if (px[g]) idle_px++;
        end
        chk("idle_px_pulses", 0, idle_px, 0);

        // Two full default-geometry lines from enable.
        @(posedge clk);
        #1 en = 1'b1;
        for (int i = 1; i <= 6400; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (px[0] && first_px == 0) first_px = i;
            if (px[0]) px0++;
            if (le[0]) le0++;
            if (px[0] && !hs_o[0]) hsl0++;
            if (px[0] && ha_o[0]) hact0++;
            if (int'(hidx[0]) > maxh0) maxh0 = int'(hidx[0]);
            if (fe[1]) fe1++;
            if (fe[2]) fe2++;
        end
        chk("first_px_edge",   0, first_px, 3);
        chk("px_count",        0, px0, 1600);
        chk("line_en_count",   0, le0, 2);
        chk("hsync_low_ticks", 0, hsl0, 192);
        chk("active_ticks",    0, hact0, 1280);
        chk("max_hidx",        0, maxh0, 639);
        chk("frame_div3_cnt",  1, fe1, 9);
        chk("frame_div1_cnt",  2, fe2, 25);

        // Reset just before the frame-ending tick of the small geometry.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (k > 0 && ((k - 1) % 24) == 20 && (((k - 1) / 24) % 10) == 5) found = 1'b1;
        end
        chk("wait_last_line", 1, 32'(found), 1);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (fe[1]) fe_after++;
        end
        chk("frame_after_rst", 1, fe_after, 0);

        // Random enable drops and asynchronous resets.
        for (int i = 0; i < 30000; i++) begin
            @(posedge clk);
            #1;
            if (!en) begin
                if (hold == 0) en = 1'b1;
                else hold--;
            end else if ($urandom_range(0, 799) == 0) begin
                en = 1'b0;
                hold = int'($urandom_range(0, 7));
            end
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 2999) == 0) begin
                #3 rst_n = 1'b0;
            end
        end
        en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
